// File: rtl/vending_core_param_pkg.sv
// vending_core_param shared types and defaults
// FSM encoding and default price / coin tables
package vending_core_param_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RETURN = 2'd2
  } state_t;

  localparam int DEF_NUM_ITEMS   = 4;
  localparam int DEF_NUM_COINS   = 3;
  localparam int DEF_TOTAL_BITS  = 31;
  localparam int DEF_WAIT_CYCLES = 100;

  localparam logic [127:0] DEF_ITEM_PRICE =
    {32'd2000, 32'd1000, 32'd500, 32'd400};
  localparam logic [95:0] DEF_COIN_VALUE =
    {32'd1000, 32'd500, 32'd100};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vending_core_param_change_picker.sv
// vending_core_param change picker
// Largest coin whose value fits in the balance
module vending_core_param_change_picker
  import vending_core_param_pkg::*;
#(
  parameter int NUM_COINS = DEF_NUM_COINS,
  parameter int BW        = DEF_TOTAL_BITS,
  parameter logic [NUM_COINS*32-1:0] COIN_VALUE = DEF_COIN_VALUE
) (
  input  logic [BW-1:0]        i_balance,
  output logic [NUM_COINS-1:0] o_coin,
  output logic [BW-1:0]        o_value
);

  localparam int CW = max_int(BW, 32) + 1;

  logic [CW-1:0] w_bal;
  logic [CW-1:0] w_cv;

  // values increase with index, so the last fitting coin wins
  always_comb begin
    o_coin  = '0;
    o_value = '0;
    w_bal   = CW'(i_balance);
    w_cv    = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      w_cv = CW'(COIN_VALUE[i*32 +: 32]);
      if (w_cv <= w_bal) begin
        o_coin    = '0;
        o_coin[i] = 1'b1;
        o_value   = BW'(w_cv);
      end
    end
  end

endmodule

// File: rtl/vending_core_param.sv
// vending_core_param top
// Balance, inactivity timer, dispense and change payout
module vending_core_param
  import vending_core_param_pkg::*;
#(
  parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
  parameter int NUM_COINS   = DEF_NUM_COINS,
  parameter int TOTAL_BITS  = DEF_TOTAL_BITS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [NUM_ITEMS*32-1:0] ITEM_PRICE = DEF_ITEM_PRICE,
  parameter logic [NUM_COINS*32-1:0] COIN_VALUE = DEF_COIN_VALUE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_COINS-1:0]  i_input_coin,
  input  logic [NUM_ITEMS-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  output logic [NUM_ITEMS-1:0]  o_available_item,
  output logic [NUM_ITEMS-1:0]  o_output_item,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic [TOTAL_BITS-1:0] o_current_total,
  output logic                  o_coin_reject,
  output logic                  o_busy
);

  localparam int CNTW = $clog2(WAIT_CYCLES + 1);
  localparam int SW   = max_int(TOTAL_BITS, 32) + NUM_COINS + 1;
  localparam logic [SW-1:0] MAX_BAL =
    {{(SW-TOTAL_BITS){1'b0}}, {TOTAL_BITS{1'b1}}};
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WAIT_CYCLES);

  state_t r_state;
  state_t w_state_nxt;

  logic [TOTAL_BITS-1:0] r_bal;
  logic [TOTAL_BITS-1:0] w_bal_nxt;
  logic [CNTW-1:0]       r_cnt;
  logic [CNTW-1:0]       w_cnt_nxt;
  logic [NUM_ITEMS-1:0]  r_item;
  logic [NUM_ITEMS-1:0]  w_item_nxt;
  logic                  r_rej;
  logic                  w_rej_nxt;

  logic [SW-1:0]         w_bal_w;
  logic [SW-1:0]         w_sum;
  logic [SW-1:0]         w_price;
  logic [SW-1:0]         w_new;
  logic [NUM_ITEMS-1:0]  w_avail;
  logic [NUM_ITEMS-1:0]  w_sel;
  logic                  w_over;
  logic                  w_coin_ok;
  logic                  w_disp;
  logic [NUM_COINS-1:0]  w_pick;
  logic [TOTAL_BITS-1:0] w_pick_val;

  vending_core_param_change_picker #(
    .NUM_COINS  (NUM_COINS),
    .BW         (TOTAL_BITS),
    .COIN_VALUE (COIN_VALUE)
  ) u_picker (
    .i_balance (r_bal),
    .o_coin    (w_pick),
    .o_value   (w_pick_val)
  );

  assign w_bal_w   = SW'(r_bal);
  assign w_over    = (w_bal_w + w_sum) > MAX_BAL;
  assign w_coin_ok = (|i_input_coin) && !w_over;
  assign w_disp    = |w_sel;

  // total value of the coins presented this cycle
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_input_coin[i]) begin
        w_sum = w_sum + SW'(COIN_VALUE[i*32 +: 32]);
      end
    end
  end

  // affordability and lowest-index affordable selection
  always_comb begin
    w_avail = '0;
    w_sel   = '0;
    w_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      w_avail[i] = SW'(ITEM_PRICE[i*32 +: 32]) <= w_bal_w;
    end
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (i_select_item[i] && w_avail[i] && (w_sel == '0)) begin
        w_sel[i] = 1'b1;
        w_price  = SW'(ITEM_PRICE[i*32 +: 32]);
      end
    end
  end

  // next state, balance, timer and registered pulses
  always_comb begin
    w_state_nxt = r_state;
    w_bal_nxt   = r_bal;
    w_cnt_nxt   = r_cnt;
    w_item_nxt  = '0;
    w_rej_nxt   = 1'b0;
    w_new       = '0;
    unique case (r_state)
      S_IDLE, S_ACTIVE: begin
        w_rej_nxt  = (|i_input_coin) && w_over;
        w_item_nxt = w_sel;
        w_new      = w_bal_w + (w_coin_ok ? w_sum : '0) - w_price;
        w_bal_nxt  = w_new[TOTAL_BITS-1:0];
        if (w_coin_ok || w_disp) begin
          w_cnt_nxt = CNT_LOAD;
        end else if ((r_state == S_ACTIVE) && (r_cnt != '0)) begin
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
        if (w_new == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_LOAD;
        end else if ((r_state == S_ACTIVE) &&
                     (i_trigger_return ||
                      (!w_coin_ok && !w_disp &&
                       (r_cnt <= CNTW'(1))))) begin
          w_state_nxt = S_RETURN;
        end else begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_RETURN: begin
        if ((w_pick == '0) || (r_bal == w_pick_val)) begin
          w_bal_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_bal_nxt = r_bal - w_pick_val;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bal_nxt   = '0;
        w_cnt_nxt   = CNT_LOAD;
      end
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_bal   <= '0;
      r_cnt   <= CNT_LOAD;
      r_item  <= '0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bal   <= w_bal_nxt;
      r_cnt   <= w_cnt_nxt;
      r_item  <= w_item_nxt;
      r_rej   <= w_rej_nxt;
    end
  end

  assign o_busy           = (r_state == S_RETURN);
  assign o_return_coin    = o_busy ? w_pick : '0;
  assign o_available_item = w_avail;
  assign o_output_item    = r_item;
  assign o_current_total  = r_bal;
  assign o_coin_reject    = r_rej;

endmodule
